// File: rtl/bin_to_gray_conv_pkg.sv
// Shared Gray-code helpers and width constants.
// Functions work on a 32-bit word; narrower users zero-extend.
package bin_to_gray_conv_pkg;

   localparam int GRAY_W_DEFAULT = 4;
   localparam int GRAY_W_MAX     = 32;

   typedef logic [GRAY_W_MAX-1:0] gword_t;

   function automatic gword_t to_gray(gword_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic gword_t from_gray(gword_t g);
      gword_t b;
      b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
      for (int i = GRAY_W_MAX-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/bin_to_gray_conv_if.sv
// Bundle of data/valid signals for the Gray converter.
// Master drives the inputs, slave is the converter.
interface bin_to_gray_conv_if
   import bin_to_gray_conv_pkg::*;
#(
   parameter int WIDTH = GRAY_W_DEFAULT
) ();

   logic [WIDTH-1:0] bin;
   logic             in_valid;
   logic [WIDTH-1:0] gray;
   logic [WIDTH-1:0] gray_q;
   logic             out_valid;
   logic [WIDTH-1:0] gray_in;
   logic [WIDTH-1:0] bin_out;

   modport master (
      output bin, in_valid, gray_in,
      input  gray, gray_q, out_valid, bin_out
   );

   modport slave (
      input  bin, in_valid, gray_in,
      output gray, gray_q, out_valid, bin_out
   );

endinterface

// File: rtl/bin_to_gray_conv_gray_to_bin.sv
// Gray-to-binary decoder, MSB-down prefix XOR.
// Each bit is the parity of all Gray bits at or above it.
module bin_to_gray_conv_gray_to_bin #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin_o[i] = ^gray_i[WIDTH-1:i];
   end

endmodule

// File: rtl/bin_to_gray_conv.sv
// Binary-to-Gray encoder with registered output path
// and a combinational Gray-to-binary decoder.
module bin_to_gray_conv
   import bin_to_gray_conv_pkg::*;
#(
   parameter int WIDTH = GRAY_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   bin_to_gray_conv_if.slave  cv
);

   logic [WIDTH-1:0] gray_c;
   logic [WIDTH-1:0] gray_d;
   logic [WIDTH-1:0] gray_q;
   logic             valid_d;
   logic             valid_q;

   assign gray_c = WIDTH'(to_gray(GRAY_W_MAX'(cv.bin)));

   // Next state: load on valid, otherwise hold code and drop valid.
   always_comb begin
      gray_d  = gray_q;
      valid_d = 1'b0;
      if (cv.in_valid) begin
         gray_d  = gray_c;
         valid_d = 1'b1;
      end
   end

   // Output register; reset wins over an incoming sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         gray_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         gray_q  <= gray_d;
         valid_q <= valid_d;
      end
   end

   assign cv.gray      = gray_c;
   assign cv.gray_q    = gray_q;
   assign cv.out_valid = valid_q;

   bin_to_gray_conv_gray_to_bin #(
      .WIDTH (WIDTH)
   ) u_dec (
      .gray_i (cv.gray_in),
      .bin_o  (cv.bin_out)
   );

endmodule

// File: tb/tb_bin_to_gray_conv.sv
// Self-checking bench: directed sweeps plus randomized
// traffic against a behavioural reference model.
module tb_bin_to_gray_conv;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   bit   chk_en;

   bin_to_gray_conv_if #(.WIDTH(4)) if4 ();
   bin_to_gray_conv_if #(.WIDTH(8)) if8 ();

   bin_to_gray_conv #(.WIDTH(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .cv  (if4)
   );

   bin_to_gray_conv #(.WIDTH(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .cv  (if8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int sweep [16] = '{0, 1, 3, 2, 6, 7, 5, 4,
                      12, 13, 15, 14, 10, 11, 9, 8};

   // Reference: Gray code by definition, decode by search.
   function automatic int enc(int b);
      return b ^ (b >> 1);
   endfunction

   function automatic int dec(int w, int g);
      for (int n = 0; n < (1 << w); n++) begin
         if (enc(n) == g) return n;
      end
      return -1;
   endfunction

   task automatic chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d @%0t",
                  name, act, exp, $time);
      end
   endtask

   int m4_q, m8_q;
   bit m4_v, m8_v;

   // Model of the registered path, sampled at the rising edge.
   always @(posedge clk) begin
      if (rst) begin
         m4_q = 0; m4_v = 0;
         m8_q = 0; m8_v = 0;
      end else begin
         m4_v = if4.in_valid;
         m8_v = if8.in_valid;
         if (if4.in_valid) m4_q = enc(int'(if4.bin));
         if (if8.in_valid) m8_q = enc(int'(if8.bin));
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("gray4", int'(if4.gray), enc(int'(if4.bin)));
         chk("bin_out4", int'(if4.bin_out), dec(4, int'(if4.gray_in)));
         chk("gray_q4", int'(if4.gray_q), m4_q);
         chk("out_valid4", int'(if4.out_valid), int'(m4_v));
         chk("gray8", int'(if8.gray), enc(int'(if8.bin)));
         chk("bin_out8", int'(if8.bin_out), dec(8, int'(if8.gray_in)));
         chk("gray_q8", int'(if8.gray_q), m8_q);
         chk("out_valid8", int'(if8.out_valid), int'(m8_v));
      end
   end

   initial begin
      int prev, first, g;
      n_cmp = 0;
      n_bad = 0;
      chk_en = 0;
      rst = 1'b1;
      if4.bin = '0; if4.in_valid = 1'b0; if4.gray_in = '0;
      if8.bin = '0; if8.in_valid = 1'b0; if8.gray_in = '0;

      // Two reset edges.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1;
      chk("rst_gray_q", int'(if4.gray_q), 0);
      chk("rst_out_valid", int'(if4.out_valid), 0);

      // Exhaustive 4-bit encode, round trip and adjacency.
      prev = 0;
      first = 0;
      for (int v = 0; v < 16; v++) begin
         @(negedge clk);
         #1;
         if4.bin = 4'(v);
         if4.gray_in = 4'(sweep[v]);
         #1;
         g = int'(if4.gray);
         chk("sweep4", g, sweep[v]);
         chk("rtrip4", int'(if4.bin_out), v);
         if (v == 0) first = g;
         else chk("adj4", $countones(prev ^ g), 1);
         prev = g;
      end
      chk("adj4_wrap", $countones(prev ^ first), 1);

      // Exhaustive 8-bit round trip and adjacency.
      for (int v = 0; v < 256; v++) begin
         #1;
         if8.bin = 8'(v);
         #1;
         g = int'(if8.gray);
         if8.gray_in = 8'(g);
         #1;
         chk("rtrip8", int'(if8.bin_out), v);
         if (v == 0) first = g;
         else chk("adj8", $countones(prev ^ g), 1);
         prev = g;
      end
      chk("adj8_wrap", $countones(prev ^ first), 1);

      // Registered path: bin=5 -> 7 one edge later, then hold.
      @(negedge clk);
      #1;
      rst = 1'b0;
      if4.in_valid = 1'b1;
      if4.bin = 4'd5;
      @(negedge clk);
      chk("reg_gray_q", int'(if4.gray_q), 7);
      chk("reg_valid", int'(if4.out_valid), 1);
      #1;
      if4.in_valid = 1'b0;
      @(negedge clk);
      chk("hold_gray_q", int'(if4.gray_q), 7);
      chk("hold_valid", int'(if4.out_valid), 0);

      // Reset beats in_valid; combinational path unaffected.
      #1;
      rst = 1'b1;
      if4.in_valid = 1'b1;
      if4.bin = 4'd9;
      #1;
      chk("prio_gray_pre", int'(if4.gray), 13);
      @(negedge clk);
      chk("prio_gray_q", int'(if4.gray_q), 0);
      chk("prio_valid", int'(if4.out_valid), 0);
      chk("prio_gray", int'(if4.gray), 13);

      // Back-to-back stream, one output per cycle.
      for (int v = 0; v < 16; v++) begin
         #1;
         rst = 1'b0;
         if4.in_valid = 1'b1;
         if4.bin = 4'(v);
         @(negedge clk);
         chk("stream_q", int'(if4.gray_q), sweep[v]);
         chk("stream_v", int'(if4.out_valid), 1);
      end

      // Randomized traffic, checked by the compare process.
      for (int c = 0; c < 400; c++) begin
         #1;
         rst = ($urandom_range(0, 15) == 0);
         if4.in_valid = 1'($urandom_range(0, 1));
         if4.bin = 4'($urandom);
         if4.gray_in = 4'($urandom);
         if8.in_valid = 1'($urandom_range(0, 1));
         if8.bin = 8'($urandom);
         if8.gray_in = 8'($urandom);
         @(negedge clk);
      end

      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bin_to_gray_conv.md
# bin_to_gray_conv

Parameterised binary-to-Gray-code converter with a matching Gray-to-binary decoder and a one-stage registered output path. Used wherever counters or indices cross into logic that needs single-bit-change encoding, e.g. FIFO pointers, rotary position, or async-crossing counters. The combinational encoder serves same-cycle consumers. The registered path, with valid, serves pipelined consumers.

## Interface
- WIDTH, 4, code width in bits; legal range 2..32.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; synchronous and active-high.
- bin  in  WIDTH  binary value to encode.
- in_valid  in  1  qualifies bin for the registered path.
- gray  out  WIDTH  combinational Gray code of bin.
- gray_q  out  WIDTH  registered Gray code.
- out_valid  out  1  qualifies gray_q.
- gray_in  in  WIDTH  Gray value to decode.
- bin_out  out  WIDTH  combinational binary value of gray_in.

## Operation
- Encoder, combinational:
  - gray[WIDTH-1] = bin[WIDTH-1].
  - gray[i] = bin[i+1] XOR bin[i] for i < WIDTH-1.
  - Equivalently, gray = bin XOR (bin >> 1), using a logical shift.
- Decoder, combinational:
  - bin_out[WIDTH-1] = gray_in[WIDTH-1].
  - bin_out[i] = bin_out[i+1] XOR gray_in[i], a prefix XOR from the MSB down.
  - Implemented as a generate loop; no lookup tables.
- Round trip: the decoder is the exact inverse of the encoder for all 2^WIDTH values.
- Registered path:
  - On a clock edge with in_valid=1: gray_q <= encode(bin) and out_valid <= 1.
  - On a clock edge with in_valid=0: gray_q holds its previous value and out_valid <= 0.
- Adjacency property: encode(n) and encode(n+1 mod 2^WIDTH) differ in exactly one bit, including the wrap from all-ones to 0.
- No X propagation: every output is a pure function of its inputs or register state.

## Timing
- gray and bin_out have zero-cycle latency and are valid in the same cycle as their inputs.
- gray_q and out_valid have one-cycle latency: they reflect the bin and in_valid sampled at the previous rising edge.
- Reset, synchronous: on a rising edge with rst=1, gray_q <= 0 and out_valid <= 0.
  - rst has priority over in_valid when both are asserted.
  - Combinational outputs are unaffected by rst.
- Reset mid-stream: the sample presented in the reset cycle is dropped, with no output for it.
  - In the cycle after rst deasserts, out_valid = 0 unless in_valid was 1 on that first non-reset edge.
- Back-to-back in_valid: one output per cycle, with no bubbles.

## Structure
- Shared package holds:
  - function `to_gray(logic [WIDTH-1:0])`;
  - function `from_gray(logic [WIDTH-1:0])`;
  - default width constant GRAY_W_DEFAULT = 4.
- Encoder and registered path live in the top module.
- One sub-module is natural: `gray_to_bin`, the decoder as a width-parameterised generate chain. Pointer-synchroniser logic reuses it independently.

## Test plan
- Exhaustive encode sweep, WIDTH=4, bin = 0..15 with 10 ns steps -> gray = 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8.
- Round trip: gray_in = gray for all 16 values -> bin_out == bin every time. Repeat with WIDTH=8 over all 256 values.
- Adjacency: for n = 0..15, popcount(gray(n) XOR gray(n+1 mod 16)) == 1, including 15 -> 0 (8 -> 0).
- Registered path: hold rst=1 for 2 cycles, then apply in_valid=1 with bin=5 -> gray_q=7 and out_valid=1 exactly one edge later. Next cycle drop in_valid -> out_valid=0 and gray_q stays 7.
- Reset priority: rst=1 and in_valid=1 with bin=9 on the same edge -> gray_q=0 and out_valid=0. Combinational gray=13 remains visible throughout.
- Streaming: in_valid=1 for 16 consecutive cycles with bin counting 0..15 -> gray_q follows the sweep sequence with one-cycle lag, no gaps.
